spi_input_conditioner: RTL
==========================

Name: spi_input_conditioner

Overview:
- Front end of the SPI memory block; directly upstream of the SPI control FSM.
- Synchronizes, debounces and edge-detects the three raw SPI pins (sclk, cs, mosi).
- Produces the rising_sclk pulse, conditioned_cs level and conditioned mosi data that the FSM and shift register consume.
- Also provides frame start/end pulses and a per-frame sclk bit counter for the FSM and for debug.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per channel (min 2).
- WAIT_TIME, 3, debounce count; a change is accepted after WAIT_TIME+1 consecutive mismatched synchronized samples.
- COUNTER_WIDTH, 3, width of each debounce counter; must hold WAIT_TIME.
- BIT_COUNT_WIDTH, 5, width of the frame bit counter.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- sclk_pin  input  1  raw SPI clock pin.
- cs_pin  input  1  raw chip select pin, active low.
- mosi_pin  input  1  raw MOSI pin.
- conditioned_sclk  output  1  debounced sclk level.
- rising_sclk  output  1  one-cycle pulse on conditioned_sclk 0->1.
- falling_sclk  output  1  one-cycle pulse on conditioned_sclk 1->0.
- conditioned_cs  output  1  debounced cs level.
- frame_start  output  1  one-cycle pulse on conditioned_cs 1->0.
- frame_end  output  1  one-cycle pulse on conditioned_cs 0->1.
- conditioned_mosi  output  1  debounced mosi level.
- bit_count  output  BIT_COUNT_WIDTH  rising_sclk pulses counted in the current frame.

Behaviour:
- Reset values (asynchronous, all flops):
  - conditioned_sclk=0, conditioned_mosi=0, conditioned_cs=1.
  - All pulses 0, bit_count=0, debounce counters 0.
  - sclk and mosi synchronizer flops reset to 0; cs synchronizer flops reset to 1. This ensures no spurious frame_start leaves reset.
- Channel pipeline (identical per channel):
  - SYNC_STAGES-flop synchronizer; "synced" is the last stage.
  - Debounce on every clk edge:
    - If synced == conditioned: counter <= 0.
    - Else if counter == WAIT_TIME: conditioned <= synced, counter <= 0, and the matching edge pulse is registered high.
    - Else: counter <= counter+1.
- Edge pulses:
  - Registered, high for exactly one clk cycle, in the cycle immediately following the edge on which conditioned changes.
  - Pulse cycle is coincident with the first cycle of the new conditioned level.
  - Rising and falling pulses are never asserted in the same cycle.
  - frame_start/frame_end are the cs channel's falling/rising pulses.
- Latency: a pin change held stable from before edge 0 appears on conditioned (and pulse) after edge SYNC_STAGES+WAIT_TIME+1. Default is edge 6.
- Glitch rejection: a mismatch lasting ≤WAIT_TIME synchronized samples returns counter to 0; no output change, no pulse.
- Bit counter, evaluated on each edge in priority order:
  1. frame_start: bit_count <= rising_sclk ? 1 : 0.
  2. Else if conditioned_cs==0 and rising_sclk: bit_count <= bit_count+1, saturating at all-ones (no wrap).
  3. Else hold.
  - bit_count holds its last value after frame_end until the next frame_start.
  - rising_sclk while conditioned_cs==1 is not counted.
- Channels are fully independent: simultaneous changes on multiple pins each resolve on their own schedule.
- Reset asserted mid-debounce or mid-frame:
  - Immediately returns all outputs to reset values.
  - Pending counts are discarded.
  - No pulse is generated on reset deassertion.

Test Plan:
- Reset idle check: hold pins sclk=0, cs=1, mosi=0; deassert reset, run 20 cycles -> conditioned_cs=1, all pulses 0, bit_count=0 throughout.
- Latency and pulse width: step sclk_pin 0->1 before edge 0, hold -> conditioned_sclk=1 and rising_sclk=1 after edge 6 only; rising_sclk=0 after edge 7; falling_sclk never asserted.
- Glitch rejection: mosi_pin high for 3 cycles then low -> conditioned_mosi stays 0. Repeat with 4 cycles high -> conditioned_mosi goes 1, later returns to 0 after the same latency.
- Full frame: drop cs_pin, wait 10 cycles, then 16 sclk periods of 16 cycles each, then raise cs_pin -> frame_start once, 16 rising_sclk pulses, bit_count=16 at end, frame_end once, bit_count holds 16.
- Saturation and re-arm: frame with 40 sclk periods -> bit_count stops at 31. Next frame_start clears it to 0; sclk toggles with cs high -> bit_count unchanged.
- Reset mid-frame: assert reset at bit_count=5 with cs low and a debounce in progress -> outputs return to reset values immediately. Release with cs_pin still low -> frame_start asserted 6 edges later, bit_count=0.

Source files
------------

// File: rtl/spi_input_conditioner.sv
// SPI pin front end: synchronizes, debounces and edge-detects sclk, cs and mosi, and
// counts rising sclk edges within each chip-select frame.
module spi_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned WAIT_TIME       = 3,
  parameter int unsigned COUNTER_WIDTH   = 3,
  parameter int unsigned BIT_COUNT_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sclk_pin,
  input  logic                       cs_pin,
  input  logic                       mosi_pin,
  output logic                       conditioned_sclk,
  output logic                       rising_sclk,
  output logic                       falling_sclk,
  output logic                       conditioned_cs,
  output logic                       frame_start,
  output logic                       frame_end,
  output logic                       conditioned_mosi,
  output logic [BIT_COUNT_WIDTH-1:0] bit_count
);

  localparam int unsigned NumCh = 3;
  localparam int unsigned ChSclk = 0;
  localparam int unsigned ChCs   = 1;
  // Channel order {mosi, cs, sclk}; cs idles high so reset release never looks like a frame.
  localparam logic [NumCh-1:0] RstLevel = 3'b010;
  localparam logic [COUNTER_WIDTH-1:0] WaitCnt = COUNTER_WIDTH'(WAIT_TIME);

  logic [NumCh-1:0] pin;
  logic [NumCh-1:0] capt_q;
  logic [SYNC_STAGES-1:0][NumCh-1:0] sync_q, sync_d;
  logic [NumCh-1:0] synced;
  logic [NumCh-1:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [NumCh-1:0] cond_q, cond_d;
  logic [NumCh-1:0] rise_q, rise_d;
  logic [NumCh-1:0] fall_q, fall_d;
  logic [BIT_COUNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

  assign pin    = {mosi_pin, cs_pin, sclk_pin};
  // Pin capture flop ahead of the synchronizer sets the overall latency to
  // SYNC_STAGES+WAIT_TIME+1 edges.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], capt_q};
  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    cond_d = cond_q;
    rise_d = '0;
    fall_d = '0;
    for (int c = 0; c < NumCh; c++) begin
      if (synced[c] == cond_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == WaitCnt) begin
        cond_d[c] = synced[c];
        cnt_d[c]  = '0;
        rise_d[c] = synced[c];
        fall_d[c] = ~synced[c];
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (fall_q[ChCs]) begin
      bit_cnt_d = rise_q[ChSclk] ? BIT_COUNT_WIDTH'(1) : '0;
    end else if (!cond_q[ChCs] && rise_q[ChSclk] && (bit_cnt_q != '1)) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capt_q    <= RstLevel;
      sync_q    <= {SYNC_STAGES{RstLevel}};
      cnt_q     <= '0;
      cond_q    <= RstLevel;
      rise_q    <= '0;
      fall_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      capt_q    <= pin;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      cond_q    <= cond_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign conditioned_sclk = cond_q[0];
  assign rising_sclk      = rise_q[0];
  assign falling_sclk     = fall_q[0];
  assign conditioned_cs   = cond_q[1];
  assign frame_start      = fall_q[1];
  assign frame_end        = rise_q[1];
  assign conditioned_mosi = cond_q[2];
  assign bit_count        = bit_cnt_q;

endmodule
